// File: rtl/fft_buf_ctrl.sv
// FFT sample-buffer sequencer: CPU loads in IDLE, then launch/compute/writeback/done.
// Optional `FFT_ABORT_EN adds abort_i to cancel an in-flight sequence.
module fft_buf_ctrl #(
  parameter int unsigned MEMWIDTH    = 32,
  parameter int unsigned WORDWIDTH   = 16,
  parameter int unsigned CALC_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_en_i,
  input  logic                         cpu_we_i,
  input  logic [$clog2(MEMWIDTH)-1:0]  cpu_addr_i,
  input  logic [WORDWIDTH-1:0]         cpu_data_i,
  output logic                         cpu_gnt_o,
  input  logic                         start_i,
  output logic                         calc_start_o,
  input  logic                         acc_valid_i,
  input  logic [WORDWIDTH-1:0]         acc_data_i,
  output logic                         acc_ready_o,
`ifdef FFT_ABORT_EN
  input  logic                         abort_i,
`endif
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic                         accel_mem_en_o,
  output logic [$clog2(MEMWIDTH)-1:0]  mem_addr_o,
  output logic [WORDWIDTH-1:0]         mem_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned AW = $clog2(MEMWIDTH);
  localparam int unsigned CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_COMPUTE,
    S_WRITEBACK,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic            err_q, err_d;
  logic            abort_c;
  logic            cpu_wr_c;
  logic            active_c;

`ifdef FFT_ABORT_EN
  assign abort_c = abort_i;
`else
  assign abort_c = 1'b0;
`endif

  assign cpu_wr_c = cpu_en_i & cpu_we_i;
  assign active_c = (state_q == S_LAUNCH) || (state_q == S_COMPUTE) || (state_q == S_WRITEBACK);

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wb_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_addr_q <= wb_addr_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_addr_d = wb_addr_q;
    err_d     = err_q;

    if ((state_q != S_IDLE) && cpu_wr_c) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LAUNCH;
          err_d   = 1'b0;
        end
      end
      S_LAUNCH: begin
        cnt_d   = CW'(CALC_CYCLES - 1);
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (cnt_q == '0) begin
          state_d   = S_WRITEBACK;
          wb_addr_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WRITEBACK: begin
        if (acc_valid_i) begin
          wb_addr_d = wb_addr_q + AW'(1);
          if (wb_addr_q == AW'(MEMWIDTH - 1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_c && active_c) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      wb_addr_d = '0;
    end
  end

  // Buffer-port mux and status decode; buffer side has no added latency
  always_comb begin
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    accel_mem_en_o = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    cpu_gnt_o      = 1'b0;
    acc_ready_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_en_o   = cpu_en_i;
        mem_we_o   = cpu_we_i;
        mem_addr_o = cpu_addr_i;
        mem_data_o = cpu_data_i;
        cpu_gnt_o  = cpu_wr_c;
      end
      S_WRITEBACK: begin
        acc_ready_o    = 1'b1;
        accel_mem_en_o = acc_valid_i & ~abort_c;
        mem_addr_o     = wb_addr_q;
        mem_data_o     = acc_data_i;
      end
      default: ;
    endcase
  end

  assign calc_start_o = (state_q == S_LAUNCH);
  assign done_o       = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_fft_buf_ctrl.sv
// Directed bench for fft_buf_ctrl: CPU load, launch timing, stalled writeback,
// error flag, reset abort and (with FFT_ABORT_EN) the abort input.
module tb_fft_buf_ctrl;
  localparam int unsigned MW = 32;
  localparam int unsigned WW = 16;
  localparam int unsigned CC = 8;
  localparam int unsigned AW = 5;

  logic          clk, rst;
  logic          cpu_en_i, cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [WW-1:0] cpu_data_i;
  logic          cpu_gnt_o, start_i, calc_start_o;
  logic          acc_valid_i;
  logic [WW-1:0] acc_data_i;
  logic          acc_ready_o;
  logic          abort_i;
  logic          mem_en_o, mem_we_o, accel_mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [WW-1:0] mem_data_o;
  logic          busy_o, done_o, err_o;

  int total = 0;
  int bad   = 0;

  fft_buf_ctrl #(.MEMWIDTH(MW), .WORDWIDTH(WW), .CALC_CYCLES(CC)) dut (
    .clk(clk), .rst(rst),
    .cpu_en_i(cpu_en_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_gnt_o(cpu_gnt_o), .start_i(start_i), .calc_start_o(calc_start_o),
    .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i), .acc_ready_o(acc_ready_o),
`ifdef FFT_ABORT_EN
    .abort_i(abort_i),
`endif
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .accel_mem_en_o(accel_mem_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1ns later
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_idle();
    cpu_en_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
  endtask

  task automatic cpu_write(input int a, input logic [WW-1:0] d);
    cpu_en_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = AW'(a); cpu_data_i = d;
  endtask

  // Pulse start, then advance through LAUNCH and COMPUTE into WRITEBACK
  task automatic go_to_wb();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (CC + 1) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {23'd0, cpu_gnt_o, calc_start_o, acc_ready_o, mem_en_o, mem_we_o,
              accel_mem_en_o, busy_o, done_o, err_o}, 32'd0);
    chk({tag, "_bus"}, {11'd0, mem_addr_o, mem_data_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0; start_i = 1'b0; acc_valid_i = 1'b0; acc_data_i = '0; abort_i = 1'b0;
    cpu_idle();
    @(negedge clk);
    step();
    #1 chk_all_zero("reset");
    rst = 1'b1;
    step();

    // CPU load of the whole buffer while idle
    for (int a = 0; a < int'(MW); a++) begin
      cpu_write(a, 16'h1000 + WW'(a));
      #1;
      chk("load_gnt", 32'(cpu_gnt_o), 32'd1);
      chk("load_en_we", {30'd0, mem_en_o, mem_we_o}, 32'd3);
      chk("load_addr", 32'(mem_addr_o), 32'(a));
      chk("load_data", 32'(mem_data_o), 32'h1000 + 32'(a));
      chk("load_busy_err_acc", {29'd0, busy_o, err_o, accel_mem_en_o}, 32'd0);
      step();
    end
    cpu_en_i = 1'b1; cpu_we_i = 1'b0;
    #1;
    chk("idle_read_gnt", 32'(cpu_gnt_o), 32'd0);
    chk("idle_read_fwd", {30'd0, mem_en_o, mem_we_o}, 32'd2);

    // Launch: calc_start the cycle after start, writeback 9 cycles after that
    cpu_idle();
    start_i = 1'b1;
    #1 chk("pre_launch_busy", 32'(busy_o), 32'd0);
    step();
    start_i = 1'b0;
    #1;
    chk("launch_pulse", 32'(calc_start_o), 32'd1);
    chk("launch_busy", 32'(busy_o), 32'd1);
    for (int c = 1; c <= int'(CC) + 1; c++) begin
      step();
      cpu_idle();
      if (c == 2) cpu_write(3, 16'hDEAD);
      #1;
      chk("calc_start_single", 32'(calc_start_o), 32'd0);
      chk("acc_ready_timing", 32'(acc_ready_o), (c == int'(CC) + 1) ? 32'd1 : 32'd0);
      if (c == 2) begin
        chk("busy_write_gnt", 32'(cpu_gnt_o), 32'd0);
        chk("busy_write_fwd", {30'd0, mem_en_o, mem_we_o}, 32'd0);
      end
      if (c == 3) chk("err_set", 32'(err_o), 32'd1);
    end
    cpu_idle();

    // Writeback with a stall every third cycle and a stray start
    k = 0;
    for (int i = 0; i < 100 && k < int'(MW); i++) begin
      acc_valid_i = (i % 3) != 2;
      acc_data_i  = 16'hA000 + WW'(k);
      start_i     = (i == 4);
      #1;
      chk("wb_accel_en", 32'(accel_mem_en_o), 32'(acc_valid_i));
      if (acc_valid_i) begin
        chk("wb_addr", 32'(mem_addr_o), 32'(k));
        chk("wb_data", 32'(mem_data_o), 32'hA000 + 32'(k));
        k++;
      end
      chk("wb_no_done", 32'(done_o), 32'd0);
      if (i == 5) chk("wb_err_held", 32'(err_o), 32'd1);
      step();
    end
    chk("wb_beats", 32'(k), 32'(MW));
    acc_valid_i = 1'b0; start_i = 1'b0;
    #1;
    chk("done_pulse", {30'd0, done_o, busy_o}, 32'd3);
    step();
    #1;
    chk("after_done", {29'd0, done_o, busy_o, err_o}, 32'd1);
    acc_valid_i = 1'b1;
    #1;
    chk("idle_valid_ignored", {30'd0, acc_ready_o, accel_mem_en_o}, 32'd0);
    acc_valid_i = 1'b0;

    // New start clears err; a write in the same cycle is still granted
    start_i = 1'b1;
    cpu_write(7, 16'h0077);
    #1 chk("start_cycle_gnt", 32'(cpu_gnt_o), 32'd1);
    step();
    start_i = 1'b0;
    cpu_idle();
    #1 chk("err_cleared", {30'd0, err_o, calc_start_o}, 32'd1);
    repeat (CC + 1) step();

    // Reset in the middle of writeback
    acc_valid_i = 1'b1;
    for (int b = 0; b < 10; b++) begin
      acc_data_i = 16'hB000 + WW'(b);
      step();
    end
    rst = 1'b0;
    step();
    #1 chk_all_zero("mid_wb_reset");
    rst = 1'b1;
    acc_valid_i = 1'b0;
    step();
    #1 chk("post_reset_idle", {30'd0, busy_o, done_o}, 32'd0);
    go_to_wb();
    acc_valid_i = 1'b1;
    for (int b = 0; b < int'(MW); b++) begin
      acc_data_i = 16'hC000 + WW'(b);
      #1;
      if (b == 0) chk("restart_addr0", {26'd0, accel_mem_en_o, mem_addr_o}, 32'h20);
      if (b == int'(MW) - 1) chk("restart_last_addr", 32'(mem_addr_o), 32'(MW - 1));
      step();
    end
    acc_valid_i = 1'b0;
    #1 chk("restart_done", 32'(done_o), 32'd1);
    step();

`ifdef FFT_ABORT_EN
    go_to_wb();
    acc_valid_i = 1'b1;
    for (int b = 0; b < 5; b++) step();
    abort_i = 1'b1;
    #1 chk("abort_no_write", 32'(accel_mem_en_o), 32'd0);
    step();
    abort_i = 1'b0;
    acc_valid_i = 1'b0;
    #1 chk("abort_idle", {30'd0, busy_o, done_o}, 32'd0);
    cpu_write(1, 16'h0001);
    #1 chk("abort_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
    step();
    cpu_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_buf_ctrl.md
Name: fft_buf_ctrl

Overview:
- Sequences and arbitrates the FFT sample buffer, a flip-flop word array with one shared write port.
- The CPU loads samples through the buffer's normal write path while the controller is idle.
- A start pulse launches the FFT datapath and waits a fixed compute latency.
- The controller then streams exactly MEMWIDTH results from the accelerator back into the buffer over the accelerator write enable, then signals completion.

Parameters:
MEMWIDTH, 32, number of buffer words; power of two, >= 2
WORDWIDTH, 16, bits per word
CALC_CYCLES, 8, datapath cycles from calc_start_o to first result; >= 1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
cpu_en_i  in  1  CPU buffer access strobe
cpu_we_i  in  1  CPU write enable
cpu_addr_i  in  $clog2(MEMWIDTH)  CPU word address
cpu_data_i  in  WORDWIDTH  CPU write data
cpu_gnt_o  out  1  CPU write accepted this cycle
start_i  in  1  start pulse from CSR
calc_start_o  out  1  one-cycle launch pulse to FFT datapath
acc_valid_i  in  1  accelerator result valid
acc_data_i  in  WORDWIDTH  accelerator result word
acc_ready_o  out  1  controller accepts result
mem_en_o  out  1  buffer en_i
mem_we_o  out  1  buffer we_i
accel_mem_en_o  out  1  buffer accelerator write enable
mem_addr_o  out  $clog2(MEMWIDTH)  buffer addr_i
mem_data_o  out  WORDWIDTH  buffer data_i
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky: CPU write refused while busy

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, compute counter 0, wb_addr 0, err_o 0; all outputs 0. Reset mid-operation aborts immediately with no done_o.
- Buffer-side outputs are combinational from state and inputs; zero added latency.
- IDLE:
  - mem_en_o=cpu_en_i, mem_we_o=cpu_we_i, mem_addr_o=cpu_addr_i, mem_data_o=cpu_data_i.
  - cpu_gnt_o=cpu_en_i&cpu_we_i; accel_mem_en_o=0.
  - start_i=1 -> LAUNCH and clear err_o. A CPU write in the same cycle is still granted.
- LAUNCH: calc_start_o=1 for exactly one cycle; counter loads CALC_CYCLES-1; -> COMPUTE.
- COMPUTE: counter decrements each cycle; at counter==0 -> WRITEBACK with wb_addr=0. COMPUTE therefore lasts CALC_CYCLES cycles.
- WRITEBACK:
  - acc_ready_o=1.
  - While acc_valid_i=1: accel_mem_en_o=1, mem_addr_o=wb_addr, mem_data_o=acc_data_i, and wb_addr increments.
  - acc_valid_i=0 inserts a stall: no write, wb_addr holds.
  - Accepted beat with wb_addr==MEMWIDTH-1 -> DONE; wb_addr wraps to 0.
- DONE: done_o=1 for one cycle; -> IDLE.
- CPU writes outside IDLE: cpu_gnt_o=0, nothing forwarded (mem_en_o=mem_we_o=0), err_o set. err_o holds until the next accepted start_i or reset.
- CPU reads (cpu_we_i=0) are never refused and never set err_o. The buffer's parallel outputs are always readable.
- start_i outside IDLE: ignored; no restart, no error.
- acc_valid_i outside WRITEBACK: ignored; acc_ready_o=0.

Optional Feature:
FFT_ABORT_EN:
- Defined: adds input abort_i (1 bit). abort_i=1 in LAUNCH, COMPUTE or WRITEBACK -> IDLE next cycle, with no done_o, counter and wb_addr cleared, and no buffer write that cycle. Words already written back stay in the buffer. abort_i in IDLE or DONE is ignored (DONE still completes).
- Undefined: no abort_i port; the sequence always runs to DONE unless reset.

Test Plan:
- CPU writes 32 words (addr k, data 16'h1000+k) in IDLE -> cpu_gnt_o=1 every cycle, mem_addr_o/mem_data_o mirror inputs, busy_o=0, err_o=0.
- start_i pulse with CALC_CYCLES=8 -> calc_start_o high exactly 1 cycle after start; acc_ready_o rises exactly 9 cycles after start.
- Writeback of 32 results (data 16'hA000+k) with acc_valid_i low every third cycle -> accel_mem_en_o only on valid beats; addresses 0..31 in order; done_o single pulse the cycle after beat 31; then IDLE.
- CPU write during COMPUTE -> cpu_gnt_o=0, mem_en_o=0, err_o=1 held until next start_i, which clears it; a second start_i during WRITEBACK is ignored.
- rst=0 during WRITEBACK at beat 10 -> all outputs 0 next cycle, no done_o; a new start gives writeback from address 0.
- FFT_ABORT_EN defined: abort_i during WRITEBACK at beat 5 -> IDLE next cycle, no done_o, no write that cycle; CPU write then granted.
